// File: rtl/pc_sequencer.sv
// Next-PC selection for the MIPS fetch stage: sequential increment, branch/jump
// redirect, exception vector, and stall hold with a deferred redirect slot.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'd100,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] pc_in,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        exception,
   output logic [31:0] next_pc,
   output logic        flush_if,
   output logic        flush_id,
   output logic [31:0] epc,
   output logic        redirect_pending
);

   localparam logic [1:0] BOOT = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic [1:0]  r_state;
   logic [31:0] r_pendTarget;
   logic [31:0] r_epc;
   logic        r_redirectPending;

   logic [1:0]  w_nextState;
   logic [31:0] w_nextPend;
   logic [31:0] w_nextEpc;
   logic [31:0] w_nextPc;
   logic        w_flushIf;
   logic        w_flushId;
   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_excVector;

   // The branch belongs to the older instruction, so it beats a same-cycle jump.
   assign w_redirect  = branch_taken | jump;
   assign w_target    = branch_taken ? (branch_target & ALIGN_MASK)
                                     : (jump_target & ALIGN_MASK);
   assign w_excVector = EXC_VECTOR & ALIGN_MASK;

   always_comb begin
      w_nextState = r_state;
      w_nextPend  = r_pendTarget;
      w_nextEpc   = r_epc;
      w_nextPc    = RESET_PC;
      w_flushIf   = 1'b0;
      w_flushId   = 1'b0;
      if (!reset_n) begin
         w_nextState = BOOT;
      end else begin
         case (r_state)
            BOOT: begin
               w_nextState = RUN;
            end
            RUN: begin
               if (exception) begin
                  w_nextPc  = w_excVector;
                  w_flushIf = 1'b1;
                  w_flushId = 1'b1;
                  w_nextEpc = pc_in;
               end else if (w_redirect && stall) begin
                  w_nextPc    = pc_in;
                  w_nextPend  = w_target;
                  w_nextState = HOLD;
               end else if (w_redirect) begin
                  w_nextPc  = w_target;
                  w_flushIf = 1'b1;
               end else if (stall) begin
                  w_nextPc = pc_in;
               end else begin
                  w_nextPc = pc_in + 32'd4;
               end
            end
            HOLD: begin
               if (exception) begin
                  w_nextPc    = w_excVector;
                  w_flushIf   = 1'b1;
                  w_flushId   = 1'b1;
                  w_nextEpc   = pc_in;
                  w_nextPend  = 32'd0;
                  w_nextState = RUN;
               end else if (stall) begin
                  w_nextPc = pc_in;
                  if (w_redirect) begin
                     w_nextPend = w_target;
                  end
               end else begin
                  w_nextPc    = r_pendTarget;
                  w_flushIf   = 1'b1;
                  w_nextState = RUN;
               end
            end
            default: begin
               w_nextState = BOOT;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state           <= BOOT;
         r_pendTarget      <= 32'd0;
         r_epc             <= 32'd0;
         r_redirectPending <= 1'b0;
      end else begin
         r_state           <= w_nextState;
         r_pendTarget      <= w_nextPend;
         r_epc             <= w_nextEpc;
         r_redirectPending <= (w_nextState == HOLD);
      end
   end

   assign next_pc          = w_nextPc;
   assign flush_if         = w_flushIf;
   assign flush_id         = w_flushId;
   assign epc              = r_epc;
   assign redirect_pending = r_redirectPending;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; pc_in is driven by the bench
// in place of the PC register so every expected value is fixed by hand.
module tb_pc_sequencer;

   logic        clock;
   logic        reset_n;
   logic [31:0] pc_in;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        exception;
   logic [31:0] next_pc;
   logic        flush_if;
   logic        flush_id;
   logic [31:0] epc;
   logic        redirect_pending;

   int total = 0;
   int bad   = 0;

   pc_sequencer dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .pc_in            (pc_in),
      .stall            (stall),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .jump             (jump),
      .jump_target      (jump_target),
      .exception        (exception),
      .next_pc          (next_pc),
      .flush_if         (flush_if),
      .flush_id         (flush_id),
      .epc              (epc),
      .redirect_pending (redirect_pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Wait past the next rising edge so registered outputs have settled.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] pc, input logic st,
                                input logic br, input logic [31:0] brT,
                                input logic jp, input logic [31:0] jpT,
                                input logic ex);
      pc_in         = pc;
      stall         = st;
      branch_taken  = br;
      branch_target = brT;
      jump          = jp;
      jump_target   = jpT;
      exception     = ex;
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      applyStimulus(32'd0, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("rst_next_pc", next_pc, 32'd100);
      checkOutput("rst_flush_if", {31'd0, flush_if}, 32'd0);
      checkOutput("rst_flush_id", {31'd0, flush_id}, 32'd0);
      checkOutput("rst_epc", epc, 32'd0);
      checkOutput("rst_pending", {31'd0, redirect_pending}, 32'd0);

      #10;
      reset_n = 1'b1;
      #1;
      checkOutput("boot_next_pc", next_pc, 32'd100);
      checkOutput("boot_flush_if", {31'd0, flush_if}, 32'd0);

      tick();
      applyStimulus(32'd100, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("seq_104", next_pc, 32'd104);
      tick();
      applyStimulus(32'd104, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("seq_108", next_pc, 32'd108);
      checkOutput("seq_flush_if", {31'd0, flush_if}, 32'd0);

      applyStimulus(32'hFFFF_FFFC, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("wrap", next_pc, 32'd0);

      applyStimulus(32'd108, 0, 1, 32'd200, 1, 32'd300, 0);
      checkOutput("br_wins", next_pc, 32'd200);
      checkOutput("br_flush_if", {31'd0, flush_if}, 32'd1);
      checkOutput("br_flush_id", {31'd0, flush_id}, 32'd0);
      tick();
      applyStimulus(32'd200, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("br_after_flush", {31'd0, flush_if}, 32'd0);
      checkOutput("br_after_pc", next_pc, 32'd204);

      applyStimulus(32'd204, 0, 0, 32'd0, 1, 32'h2FF, 0);
      checkOutput("jmp_align", next_pc, 32'h2FC);
      tick();

      // Stall window: jump latched, younger branch overwrites it, release ignores new jump.
      applyStimulus(32'h100, 1, 0, 32'd0, 1, 32'h40, 0);
      checkOutput("st1_pc", next_pc, 32'h100);
      checkOutput("st1_flush", {31'd0, flush_if}, 32'd0);
      checkOutput("st1_pending", {31'd0, redirect_pending}, 32'd0);
      tick();
      applyStimulus(32'h100, 1, 1, 32'h80, 0, 32'd0, 0);
      checkOutput("st2_pc", next_pc, 32'h100);
      checkOutput("st2_pending", {31'd0, redirect_pending}, 32'd1);
      tick();
      applyStimulus(32'h100, 1, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("st3_pc", next_pc, 32'h100);
      checkOutput("st3_pending", {31'd0, redirect_pending}, 32'd1);
      tick();
      applyStimulus(32'h100, 0, 0, 32'd0, 1, 32'h500, 0);
      checkOutput("rel_pc", next_pc, 32'h80);
      checkOutput("rel_flush_if", {31'd0, flush_if}, 32'd1);
      checkOutput("rel_flush_id", {31'd0, flush_id}, 32'd0);
      tick();
      applyStimulus(32'h80, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("rel_pending_low", {31'd0, redirect_pending}, 32'd0);
      checkOutput("rel_seq", next_pc, 32'h84);

      applyStimulus(32'h120, 1, 0, 32'd0, 1, 32'h40, 0);
      tick();
      applyStimulus(32'h120, 1, 0, 32'd0, 0, 32'd0, 1);
      checkOutput("exh_pc", next_pc, 32'h8000_0180);
      checkOutput("exh_flush_if", {31'd0, flush_if}, 32'd1);
      checkOutput("exh_flush_id", {31'd0, flush_id}, 32'd1);
      checkOutput("exh_pending_before", {31'd0, redirect_pending}, 32'd1);
      tick();
      applyStimulus(32'h8000_0180, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("exh_epc", epc, 32'h120);
      checkOutput("exh_pending_after", {31'd0, redirect_pending}, 32'd0);
      checkOutput("exh_dropped", next_pc, 32'h8000_0184);
      checkOutput("exh_flush_once", {31'd0, flush_id}, 32'd0);

      applyStimulus(32'h200, 1, 1, 32'h300, 0, 32'd0, 1);
      checkOutput("exr_pc", next_pc, 32'h8000_0180);
      tick();
      applyStimulus(32'h204, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("exr_epc", epc, 32'h200);
      checkOutput("exr_no_hold", {31'd0, redirect_pending}, 32'd0);
      checkOutput("exr_seq", next_pc, 32'h208);

      applyStimulus(32'h300, 1, 0, 32'd0, 1, 32'h40, 0);
      tick();
      checkOutput("mid_hold", {31'd0, redirect_pending}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_pc", next_pc, 32'd100);
      checkOutput("mid_rst_epc", epc, 32'd0);
      checkOutput("mid_rst_pending", {31'd0, redirect_pending}, 32'd0);
      checkOutput("mid_rst_flush", {31'd0, flush_if}, 32'd0);
      tick();
      reset_n = 1'b1;
      applyStimulus(32'd0, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("mid_boot_pc", next_pc, 32'd100);
      tick();
      applyStimulus(32'd100, 0, 0, 32'd0, 0, 32'd0, 0);
      checkOutput("mid_resume", next_pc, 32'd104);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
